// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg : shared pipeline types for the hazard controller             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_BRPEND  = 2'd2,
      ST_BAD     = 2'd3
   } hz_state_t;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_en_t;

   localparam stage_en_t EN_ALL  = 5'b11111;
   localparam stage_en_t EN_NONE = 5'b00000;
   // Load-use hold: freeze PC and IF/ID, let the bubble flow down the pipe.
   localparam stage_en_t EN_LDU  = 5'b00111;

   function automatic logic load_use(
      input logic       ex_memread,
      input logic [4:0] ex_rw,
      input logic [4:0] id_rn,
      input logic [4:0] id_rm,
      input logic       id_uses_rm,
      input logic [4:0] zero_reg
   );
      return ex_memread && (ex_rw != zero_reg) &&
             ((ex_rw == id_rn) || (id_uses_rm && (ex_rw == id_rm)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// +----------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline <-> hazard controller signal bundle         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rn;
   logic [4:0]       id_rm;
   logic             id_uses_rm;
   logic [4:0]       ex_rw;
   logic             ex_memread;
   logic             mem_br_taken;
   logic             dmem_req;
   logic             dmem_ready;

   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             exmem_we;
   logic             memwb_we;
   logic             idex_bubble;
   logic             flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rn, id_rm, id_uses_rm, ex_rw, ex_memread,
             mem_br_taken, dmem_req, dmem_ready,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             idex_bubble, flush, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rn, id_rm, id_uses_rm, ex_rw, ex_memread,
             mem_br_taken, dmem_req, dmem_ready,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             idex_bubble, flush, state, stall_cnt, flush_cnt
   );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter : event counter that sticks at all-ones                   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != C_MAX)) begin
         count <= count + C_ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | hazard_ctrl : stall/flush controller for a 5-stage in-order pipeline  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl #(
   parameter int         CNT_W = 32,
   parameter logic [4:0] XZR   = cpu_pkg::XZR
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);
   import cpu_pkg::*;

   hz_state_t cur_state;
   hz_state_t nxt_state;
   stage_en_t en;
   logic      bubble;
   logic      flush_now;
   logic      ldu;
   logic      memstall;
   logic      go;

   assign ldu      = load_use(bus.ex_memread, bus.ex_rw, bus.id_rn,
                              bus.id_rm, bus.id_uses_rm, XZR);
   assign memstall = bus.dmem_req && !bus.dmem_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_state <= ST_RUN;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // A branch seen while memory is stalled is parked in BRPEND so it is
   // flushed exactly once, when the access finally completes.
   always_comb begin
      nxt_state = ST_RUN;
      case (cur_state)
         ST_RUN: begin
            if (memstall) begin
               nxt_state = bus.mem_br_taken ? ST_BRPEND : ST_MEMWAIT;
            end
         end
         ST_MEMWAIT: begin
            if (!bus.dmem_ready) begin
               nxt_state = bus.mem_br_taken ? ST_BRPEND : ST_MEMWAIT;
            end
         end
         ST_BRPEND: begin
            nxt_state = bus.dmem_ready ? ST_RUN : ST_BRPEND;
         end
         default: nxt_state = ST_RUN;
      endcase
   end

   always_comb begin
      en        = EN_NONE;
      bubble    = 1'b0;
      flush_now = 1'b0;
      go        = 1'b0;
      case (cur_state)
         ST_RUN:     go = !memstall;
         ST_MEMWAIT: go = bus.dmem_ready;
         ST_BRPEND: begin
            if (bus.dmem_ready) begin
               en        = EN_ALL;
               flush_now = 1'b1;
            end
         end
         default: go = 1'b0;
      endcase
      if (go) begin
         if (bus.mem_br_taken) begin
            en        = EN_ALL;
            flush_now = 1'b1;
         end else if (ldu) begin
            en     = EN_LDU;
            bubble = 1'b1;
         end else begin
            en = EN_ALL;
         end
      end
   end

   assign bus.pc_we       = en.pc;
   assign bus.ifid_we     = en.ifid;
   assign bus.idex_we     = en.idex;
   assign bus.exmem_we    = en.exmem;
   assign bus.memwb_we    = en.memwb;
   assign bus.idex_bubble = bubble;
   assign bus.flush       = flush_now;
   assign bus.state       = cur_state;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!en.pc),
      .count (bus.stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_now),
      .count (bus.flush_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl : directed + random check of hazard_ctrl               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   bit   chk_on = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   hazard_ctrl_if #(.CNT_W(CW)) bus ();

   hazard_ctrl #(.CNT_W(CW), .XZR(5'd31)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: "waiting for memory" and "branch owed" flags.
   bit m_wait = 1'b0;
   bit m_br   = 1'b0;
   int m_stall = 0;
   int m_flush = 0;
   bit e_front, e_back, e_bub, e_fl, frozen, ldu, nx_wait, nx_br;
   int e_state;

   always @(negedge clk) begin
      if (chk_on) begin
         ldu = bus.ex_memread && (bus.ex_rw != 5'd31) &&
               ((bus.ex_rw == bus.id_rn) || (bus.id_uses_rm && (bus.ex_rw == bus.id_rm)));
         frozen = (m_wait || m_br) ? !bus.dmem_ready
                                   : (bus.dmem_req && !bus.dmem_ready);
         e_front = 1'b0; e_back = 1'b0; e_bub = 1'b0; e_fl = 1'b0;
         if (frozen) begin
            nx_wait = 1'b1;
            nx_br   = m_br || bus.mem_br_taken;
         end else begin
            nx_wait = 1'b0;
            nx_br   = 1'b0;
            e_back  = 1'b1;
            e_fl    = m_br || bus.mem_br_taken;
            if (!e_fl && ldu) e_bub = 1'b1;
            else              e_front = 1'b1;
         end
         e_state = m_br ? 2 : (m_wait ? 1 : 0);
         chk("pc_we",       int'(bus.pc_we),       int'(e_front));
         chk("ifid_we",     int'(bus.ifid_we),     int'(e_front));
         chk("idex_we",     int'(bus.idex_we),     int'(e_back));
         chk("exmem_we",    int'(bus.exmem_we),    int'(e_back));
         chk("memwb_we",    int'(bus.memwb_we),    int'(e_back));
         chk("idex_bubble", int'(bus.idex_bubble), int'(e_bub));
         chk("flush",       int'(bus.flush),       int'(e_fl));
         chk("state",       int'(bus.state),       e_state);
         chk("stall_cnt",   int'(bus.stall_cnt),   m_stall);
         chk("flush_cnt",   int'(bus.flush_cnt),   m_flush);
         if (!reset) begin
            m_wait = 1'b0; m_br = 1'b0; m_stall = 0; m_flush = 0;
         end else begin
            m_wait = nx_wait;
            m_br   = nx_br;
            if (!e_front && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX)     m_flush++;
         end
      end
   end

   task automatic set_in(input int rn, input int rm, input bit urm, input int rw,
                         input bit mr, input bit br, input bit req, input bit rdy);
      bus.id_rn        = 5'(rn);
      bus.id_rm        = 5'(rm);
      bus.id_uses_rm   = urm;
      bus.ex_rw        = 5'(rw);
      bus.ex_memread   = mr;
      bus.mem_br_taken = br;
      bus.dmem_req     = req;
      bus.dmem_ready   = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   function automatic int pick_reg();
      int k;
      k = int'($urandom_range(0, 4));
      return (k == 4) ? 31 : k;
   endfunction

   initial begin
      idle();
      tick();
      tick();
      reset  = 1'b1;
      chk_on = 1'b1;
      chk("rst_state", int'(bus.state), 0);
      chk("rst_stall", int'(bus.stall_cnt), 0);
      chk("rst_flush", int'(bus.flush_cnt), 0);

      // load-use on rn
      set_in(3, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      mid();
      chk("ldu_pc_we", int'(bus.pc_we), 0);
      chk("ldu_ifid_we", int'(bus.ifid_we), 0);
      chk("ldu_bubble", int'(bus.idex_bubble), 1);
      chk("ldu_idex_we", int'(bus.idex_we), 1);
      tick();
      idle();
      chk("ldu_stall_cnt", int'(bus.stall_cnt), 1);

      // zero register never hazards
      set_in(5, 31, 1'b1, 31, 1'b1, 1'b0, 1'b0, 1'b0);
      mid();
      chk("xzr_pc_we", int'(bus.pc_we), 1);
      chk("xzr_ifid_we", int'(bus.ifid_we), 1);
      chk("xzr_bubble", int'(bus.idex_bubble), 0);
      tick();
      idle();
      chk("xzr_stall_cnt", int'(bus.stall_cnt), 1);

      // branch flush
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      mid();
      chk("br_flush", int'(bus.flush), 1);
      chk("br_pc_we", int'(bus.pc_we), 1);
      tick();
      idle();
      chk("br_flush_cnt", int'(bus.flush_cnt), 1);
      chk("br_state", int'(bus.state), 0);

      // memory wait: 3 stalled cycles then ready
      do_reset();
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      mid();
      chk("mw_pc_we0", int'(bus.pc_we), 0);
      tick();
      mid();
      chk("mw_state", int'(bus.state), 1);
      chk("mw_memwb_we", int'(bus.memwb_we), 0);
      tick();
      mid();
      chk("mw_pc_we2", int'(bus.pc_we), 0);
      tick();
      bus.dmem_ready = 1'b1;
      mid();
      chk("mw_ready_pc_we", int'(bus.pc_we), 1);
      chk("mw_stall_cnt", int'(bus.stall_cnt), 3);
      tick();
      idle();
      chk("mw_back_run", int'(bus.state), 0);

      // branch during memory wait
      do_reset();
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      bus.mem_br_taken = 1'b1;
      mid();
      chk("bw_state_mw", int'(bus.state), 1);
      chk("bw_no_flush0", int'(bus.flush), 0);
      tick();
      bus.mem_br_taken = 1'b0;
      mid();
      chk("bw_state_bp", int'(bus.state), 2);
      chk("bw_no_flush1", int'(bus.flush), 0);
      tick();
      mid();
      chk("bw_hold_pc_we", int'(bus.pc_we), 0);
      tick();
      bus.dmem_ready = 1'b1;
      mid();
      chk("bw_flush", int'(bus.flush), 1);
      chk("bw_all_we", int'(bus.exmem_we), 1);
      tick();
      idle();
      chk("bw_state_run", int'(bus.state), 0);
      chk("bw_flush_cnt", int'(bus.flush_cnt), 1);

      // saturation, then reset in the middle of a memory wait
      do_reset();
      set_in(2, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (9) tick();
      chk("sat_stall_cnt", int'(bus.stall_cnt), 7);
      set_in(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      chk("sat_in_mw", int'(bus.state), 1);
      reset = 1'b0;
      tick();
      chk("rstmw_state", int'(bus.state), 0);
      chk("rstmw_stall", int'(bus.stall_cnt), 0);
      chk("rstmw_flush", int'(bus.flush_cnt), 0);
      reset = 1'b1;
      mid();
      chk("rstmw_run_dec", int'(bus.pc_we), 0);
      tick();

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         set_in(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), pick_reg(),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 40),
                ($urandom_range(0, 1) == 1));
         reset = ($urandom_range(0, 99) >= 2);
         tick();
      end
      reset = 1'b1;
      idle();
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of each event counter.
REQ-002 The block SHALL have parameter XZR, default 5'd31, naming the zero register, which never creates a hazard.
REQ-003 Port clk  in  1  rising-edge clock for all state.
REQ-004 Port reset  in  1  reset, synchronous, active-low.
REQ-005 Port id_rn  in  5  first source register of the instruction in ID.
REQ-006 Port id_rm  in  5  second source register of the instruction in ID.
REQ-007 Port id_uses_rm  in  1  ID instruction reads id_rm.
REQ-008 Port ex_rw  in  5  destination register held in the ID/EX register.
REQ-009 Port ex_memread  in  1  ID/EX instruction is a load.
REQ-010 Port mem_br_taken  in  1  branch in the EX/MEM register resolved taken.
REQ-011 Port dmem_req  in  1  MEM-stage data-memory access active.
REQ-012 Port dmem_ready  in  1  data memory completes the access this cycle.
REQ-013 Port pc_we  out  1  PC write enable.
REQ-014 Port ifid_we  out  1  IF/ID write enable.
REQ-015 Port idex_we, exmem_we, memwb_we  out  1 each  stage write enables.
REQ-016 Port idex_bubble  out  1  load zeroed control (EX/MEM/WB fields) into ID/EX.
REQ-017 Port flush  out  1  zero IF/ID and ID/EX, and zero control into EX/MEM.
REQ-018 Port state  out  2  current FSM state encoding.
REQ-019 Port stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-020 The FSM SHALL have states RUN=0, MEMWAIT=1, BRPEND=2; code 3 SHALL return to RUN on the next clock.
REQ-021 Load-use: ldu = ex_memread & ex_rw!=XZR & (ex_rw==id_rn | (id_uses_rm & ex_rw==id_rm)).
REQ-022 memstall = dmem_req & ~dmem_ready; outputs SHALL be combinational from state and inputs.
REQ-023 In RUN with memstall, all five *_we SHALL be 0, and the next state SHALL be MEMWAIT if mem_br_taken=0, else BRPEND.
REQ-024 In RUN with mem_br_taken and no memstall, flush=1 in the same cycle, all *_we=1, and the next state SHALL be RUN.
REQ-025 In RUN with ldu and neither memstall nor mem_br_taken, pc_we=ifid_we=0, idex_bubble=1, and the other *_we=1, for exactly the cycles ldu stays true.
REQ-026 In RUN with no event, all *_we=1, flush=0, and idex_bubble=0.
REQ-027 Priority SHALL be memstall > mem_br_taken > ldu.
REQ-028 A branch flush SHALL override ldu: no bubble is inserted in that cycle.
REQ-029 In MEMWAIT, all *_we SHALL stay 0 while dmem_ready=0, and mem_br_taken asserting SHALL move the state to BRPEND.
REQ-030 In MEMWAIT, dmem_ready=1 SHALL give RUN-cycle behaviour per REQ-024..026 that cycle, and the next state SHALL be RUN.
REQ-031 In BRPEND, all *_we SHALL be held 0 until dmem_ready=1; in that cycle flush=1 and all *_we=1, and the next state SHALL be RUN.
REQ-032 A taken branch SHALL never be lost; flush SHALL assert exactly once per branch.
REQ-033 stall_cnt SHALL increment on every cycle with pc_we=0.
REQ-034 flush_cnt SHALL increment on every cycle with flush=1.
REQ-035 Both counters SHALL saturate at all-ones with no wrap.

Reset
REQ-036 When reset=0 at a rising clock edge: state=RUN, stall_cnt=0, flush_cnt=0.
REQ-037 Reset SHALL discard any pending branch or memory wait.
REQ-038 Outputs SHALL reflect RUN decoding from the first cycle after reset, so the *_we values follow the inputs.

Structure
REQ-039 The state enum, XZR, and the stage-enable bundle type SHALL live in the shared package cpu_pkg.
REQ-040 A single sub-module sat_counter (parameter CNT_W; inputs clk, reset, inc; output count) SHALL be instantiated twice.
REQ-041 The block SHALL contain no other sub-modules or memories.

Verification
REQ-042 Load-use: ex_memread=1, ex_rw=3, id_rn=3 for one cycle -> pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1.
REQ-043 Zero register: ex_memread=1, ex_rw=31, id_rm=31, id_uses_rm=1 -> no stall; all *_we=1.
REQ-044 Branch: mem_br_taken=1 for 1 cycle -> flush=1 that cycle; flush_cnt=1; state stays RUN.
REQ-045 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> *_we=0 for 3 cycles; state=MEMWAIT; stall_cnt=3.
REQ-046 Branch during wait: in MEMWAIT, pulse mem_br_taken, hold ready=0 for 2 cycles, then ready=1 -> state=BRPEND; a single flush on the ready cycle; flush_cnt=1.
REQ-047 Saturation and reset: run with CNT_W=3 and 9 stalls -> stall_cnt=7; then reset=0 mid-MEMWAIT -> state=RUN with both counters 0 the next cycle.
